// File: rtl/div_pkg.sv
// Shared types for the bitslice divider sequencer: FSM state encoding and
// the bundle of control lines that fan out to every slice of the array.
package div_pkg;

  localparam int DIV_WIDTH   = 16;
  localparam int DIV_LATENCY = DIV_WIDTH + 4;

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXUP, STORE, DONE} div_state_t;

  typedef struct packed {
    logic load_divl;
    logic load_divh;
    logic load_acc;
    logic store_acc;
    logic store_quot;
    logic store_rem;
    logic inv_op1;
    logic inv_op2;
    logic inv_result;
    logic inv_rem;
    logic op1_inv_cin;
    logic op2_inv_cin;
    logic result_inv_cin;
    logic acc_inv_cin;
    logic acc_cin;
    logic q_bit;
  } div_ctrl_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the shift-subtract phase: counts 0..WIDTH-1 and
// holds at the terminal count so it can never wrap inside an operation.
module div_iter_counter #(
  parameter int WIDTH = 16
) (
  input  logic gclk,
  input  logic grst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(WIDTH - 1));

  // Clear on reset or at operand load, advance once per iteration cycle.
  always_ff @(posedge gclk) begin
    if (grst || clr)      cnt <= '0;
    else if (en && !tc)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/div_sequencer.sv
// Control sequencer for the WIDTH-slice restoring divider array. Walks
// LOAD -> WIDTH x ITER -> FIXUP -> STORE -> DONE and decodes the slice
// control lines from the registered state plus the sign/zero flags latched
// at Start, so Start never reaches the outputs combinationally.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Signed,
  input  logic Op1_Sign,
  input  logic Op2_Sign,
  input  logic Div_Zero,
  input  logic Trial_Cout,
  output logic Busy,
  output logic Done,
  output logic Error,
  output logic LOAD_DIVL,
  output logic LOAD_DIVH,
  output logic LOAD_ACC,
  output logic STORE_ACC,
  output logic STORE_QUOT,
  output logic STORE_REM,
  output logic INV_OP1,
  output logic INV_OP2,
  output logic INV_RESULT,
  output logic INV_REM,
  output logic OP1_INV_Cin,
  output logic OP2_INV_Cin,
  output logic RESULT_INV_Cin,
  output logic ACC_INV_Cin,
  output logic ACC_Cin,
  output logic Q_Bit
);

  div_state_t state;
  logic       neg1, neg2, zero_flag;
  logic       cnt_tc;
  div_ctrl_t  ctrl;

  div_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .gclk (Clock),
    .grst (Reset),
    .clr  (state == LOAD),
    .en   (state == ITER),
    .tc   (cnt_tc)
  );

  // Sequencer state and the operand flags captured with the start command.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      neg1      <= 1'b0;
      neg2      <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          neg1      <= Signed & Op1_Sign;
          neg2      <= Signed & Op2_Sign;
          zero_flag <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          if (Div_Zero) begin
            zero_flag <= 1'b1;
            state     <= DONE;
          end else begin
            state     <= ITER;
          end
        end
        ITER:    if (cnt_tc) state <= FIXUP;
        FIXUP:   state <= STORE;
        STORE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Control decode; only Q_Bit/STORE_ACC in ITER follow Trial_Cout directly.
  always_comb begin
    ctrl  = '0;
    Busy  = (state != IDLE);
    Done  = 1'b0;
    Error = 1'b0;
    case (state)
      LOAD: begin
        ctrl.load_divl   = 1'b1;
        ctrl.load_divh   = 1'b1;
        ctrl.load_acc    = 1'b1;
        ctrl.store_acc   = 1'b1;
        ctrl.inv_op1     = neg1;
        ctrl.op1_inv_cin = neg1;
        ctrl.inv_op2     = neg2;
        ctrl.op2_inv_cin = neg2;
      end
      ITER: begin
        // DIV enables with LOAD_ACC low select the shifted neighbour path.
        ctrl.load_divl   = 1'b1;
        ctrl.load_divh   = 1'b1;
        ctrl.acc_inv_cin = 1'b1;
        ctrl.acc_cin     = 1'b1;
        ctrl.q_bit       = Trial_Cout;
        ctrl.store_acc   = Trial_Cout;
      end
      FIXUP, STORE: begin
        ctrl.inv_result     = neg1 ^ neg2;
        ctrl.result_inv_cin = neg1 ^ neg2;
        ctrl.inv_rem        = neg2;
        ctrl.acc_inv_cin    = neg2;
        ctrl.store_quot     = (state == STORE);
        ctrl.store_rem      = (state == STORE);
      end
      DONE: begin
        Done  = 1'b1;
        Error = zero_flag;
      end
      default: ;
    endcase
  end

  assign LOAD_DIVL      = ctrl.load_divl;
  assign LOAD_DIVH      = ctrl.load_divh;
  assign LOAD_ACC       = ctrl.load_acc;
  assign STORE_ACC      = ctrl.store_acc;
  assign STORE_QUOT     = ctrl.store_quot;
  assign STORE_REM      = ctrl.store_rem;
  assign INV_OP1        = ctrl.inv_op1;
  assign INV_OP2        = ctrl.inv_op2;
  assign INV_RESULT     = ctrl.inv_result;
  assign INV_REM        = ctrl.inv_rem;
  assign OP1_INV_Cin    = ctrl.op1_inv_cin;
  assign OP2_INV_Cin    = ctrl.op2_inv_cin;
  assign RESULT_INV_Cin = ctrl.result_inv_cin;
  assign ACC_INV_Cin    = ctrl.acc_inv_cin;
  assign ACC_Cin        = ctrl.acc_cin;
  assign Q_Bit          = ctrl.q_bit;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: a small behavioural model of the bitslice array
// is steered by the DUT's control lines and supplies Trial_Cout; final
// quotient/remainder are compared against constant expectations queued at
// Start, and every cycle's control word is compared against a timeline.
module tb_div_sequencer;
  localparam int W = 16;

  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Signed = 1'b0;
  logic Op1_Sign = 1'b0, Op2_Sign = 1'b0, Div_Zero = 1'b0, Trial_Cout = 1'b0;
  logic Busy, Done, Error, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, STORE_ACC;
  logic STORE_QUOT, STORE_REM, INV_OP1, INV_OP2, INV_RESULT, INV_REM;
  logic OP1_INV_Cin, OP2_INV_Cin, RESULT_INV_Cin, ACC_INV_Cin, ACC_Cin, Q_Bit;

  div_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
    .Op1_Sign(Op1_Sign), .Op2_Sign(Op2_Sign), .Div_Zero(Div_Zero),
    .Trial_Cout(Trial_Cout), .Busy(Busy), .Done(Done), .Error(Error),
    .LOAD_DIVL(LOAD_DIVL), .LOAD_DIVH(LOAD_DIVH), .LOAD_ACC(LOAD_ACC),
    .STORE_ACC(STORE_ACC), .STORE_QUOT(STORE_QUOT), .STORE_REM(STORE_REM),
    .INV_OP1(INV_OP1), .INV_OP2(INV_OP2), .INV_RESULT(INV_RESULT),
    .INV_REM(INV_REM), .OP1_INV_Cin(OP1_INV_Cin), .OP2_INV_Cin(OP2_INV_Cin),
    .RESULT_INV_Cin(RESULT_INV_Cin), .ACC_INV_Cin(ACC_INV_Cin),
    .ACC_Cin(ACC_Cin), .Q_Bit(Q_Bit)
  );

  always #5 Clock = ~Clock;

  logic [18:0] act_ctrl;
  assign act_ctrl = {Busy, Done, Error, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, STORE_ACC,
                     STORE_QUOT, STORE_REM, INV_OP1, INV_OP2, INV_RESULT, INV_REM,
                     OP1_INV_Cin, OP2_INV_Cin, RESULT_INV_Cin, ACC_INV_Cin, ACC_Cin, Q_Bit};

  typedef struct {
    logic        sgn;
    logic [15:0] dvsr;   // Operand1
    logic [15:0] dvnd;   // Operand2
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          lat;
  } sb_t;

  sb_t sbq[$];
  int  n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // st: 0 idle, 1 load, 2 iter, 3 fixup, 4 store, 5 done
  function automatic logic [18:0] exp_ctrl(input int st, input logic n1, input logic n2,
                                           input logic tc, input logic err);
    logic x;
    x = n1 ^ n2;
    case (st)
      1: return {3'b100, 3'b111, 1'b1, 2'b00, n1, n2, 2'b00, n1, n2, 1'b0, 2'b00, 1'b0};
      2: return {3'b100, 3'b000, tc, 2'b00, 4'b0000, 2'b00, 1'b0, 2'b11, tc};
      3: return {3'b100, 3'b000, 1'b0, 2'b00, 2'b00, x, n2, 2'b00, x, n2, 1'b0, 1'b0};
      4: return {3'b100, 3'b000, 1'b0, 2'b11, 2'b00, x, n2, 2'b00, x, n2, 1'b0, 1'b0};
      5: return {1'b1, 1'b1, err, 16'h0};
      default: return 19'h0;
    endcase
  endfunction

  task automatic do_op(input vec_t v, input int glitch_c, input int rst_c);
    logic n1, n2, tc, stored, seen, aborted;
    logic [32:0] dvs, acc, acc_sh;
    logic [15:0] dl, q, rq, rr, t16;
    logic [18:0] m;
    int lat, st;
    sb_t got;
    n1 = v.sgn & v.dvsr[15];
    n2 = v.sgn & v.dvnd[15];
    lat = v.ez ? 2 : W + 4;
    sbq.push_back('{v.eq, v.er, v.ez, lat});
    Start = 1'b1; Signed = v.sgn; Op1_Sign = v.dvsr[15]; Op2_Sign = v.dvnd[15];
    Div_Zero = (v.dvsr == 16'h0);
    dvs = '0; acc = '0; acc_sh = '0; dl = '0; q = '0; rq = '0; rr = '0;
    stored = 1'b0; seen = 1'b0; aborted = 1'b0;
    for (int c = 1; c <= 40 && !seen && !aborted; c++) begin
      @(negedge Clock);
      Start = (c == glitch_c);
      if (c == 1)          st = 1;
      else if (v.ez)       st = (c == 2) ? 5 : 0;
      else if (c <= W + 1) st = 2;
      else if (c == W + 2) st = 3;
      else if (c == W + 3) st = 4;
      else if (c == W + 4) st = 5;
      else                 st = 0;
      tc = 1'b0;
      if (st == 2) begin
        acc_sh = {acc[31:0], dl[15]};
        tc = (acc_sh >= dvs);
      end
      Trial_Cout = tc;
      #1;
      m = (st == 2) ? ~19'h0C000 : ~19'h0;
      chk($sformatf("ctrl c%0d", c), 32'(act_ctrl & m), 32'(exp_ctrl(st, n1, n2, tc, v.ez) & m));
      // Array model driven by the DUT's own enables and selects.
      if (st == 1) begin
        t16 = INV_OP1 ? 16'(-v.dvsr) : v.dvsr;
        dvs = {17'h0, t16};
        dl  = INV_OP2 ? 16'(-v.dvnd) : v.dvnd;
        acc = '0;
      end
      if (st == 2) begin
        acc = STORE_ACC ? (acc_sh - dvs) : acc_sh;
        q   = {q[14:0], Q_Bit};
        dl  = dl << 1;
      end
      if (STORE_QUOT) begin
        rq = INV_RESULT ? 16'(-q) : q;
        rr = INV_REM ? 16'(-acc[15:0]) : acc[15:0];
        stored = 1'b1;
      end
      if (Done) begin
        seen = 1'b1;
        got = sbq.pop_front();
        chk("latency", c, got.lat);
        chk("error", {31'h0, Error}, {31'h0, got.err});
        if (got.err) chk("no store on div0", {31'h0, stored}, 32'h0);
        else begin
          chk("quotient", {16'h0, rq}, {16'h0, got.q});
          chk("remainder", {16'h0, rr}, {16'h0, got.r});
        end
      end
      if (c == rst_c && !seen) begin
        Reset = 1'b1; Trial_Cout = 1'b0;
        @(negedge Clock); #1;
        chk("after reset", {13'h0, act_ctrl}, 32'h0);
        Reset = 1'b0;
        void'(sbq.pop_front());
        aborted = 1'b1;
      end
    end
    Trial_Cout = 1'b0;
    if (!seen && !aborted) begin
      n_vec++; n_bad++;
      $display("FAIL done timeout: no Done within 40 cycles");
      void'(sbq.pop_front());
    end
    if (seen) begin
      @(negedge Clock); #1;
      chk("idle after done", {13'h0, act_ctrl}, 32'h0);
    end
  endtask

  vec_t tbl[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          sgn   divisor   dividend   quot      rem       div0
    tbl[0]  = '{1'b0, 16'd7,    16'd100,   16'd14,   16'd2,    1'b0};
    tbl[1]  = '{1'b1, 16'd7,    -16'sd100, 16'hFFF2, 16'hFFFE, 1'b0};
    tbl[2]  = '{1'b1, -16'sd7,  16'd100,   16'hFFF2, 16'd2,    1'b0};
    tbl[3]  = '{1'b1, -16'sd7,  -16'sd100, 16'd14,   16'hFFFE, 1'b0};
    tbl[4]  = '{1'b0, 16'd1,    16'hFFFF,  16'hFFFF, 16'd0,    1'b0};
    tbl[5]  = '{1'b0, 16'd9,    16'd5,     16'd0,    16'd5,    1'b0};
    tbl[6]  = '{1'b0, 16'h8000, 16'hFFFF,  16'd1,    16'h7FFF, 1'b0};
    tbl[7]  = '{1'b1, 16'd1,    16'h8000,  16'h8000, 16'd0,    1'b0};
    tbl[8]  = '{1'b1, 16'hFFFF, 16'd1234,  16'hFB2E, 16'd0,    1'b0};
    tbl[9]  = '{1'b0, 16'h8001, 16'hFFFF,  16'd1,    16'h7FFE, 1'b0};
    tbl[10] = '{1'b1, 16'd0,    -16'sd5,   16'd0,    16'd0,    1'b1};

    repeat (3) @(negedge Clock);
    #1;
    chk("reset state", {13'h0, act_ctrl}, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) do_op(tbl[i], 0, 0);

    // Unsigned divide-by-zero.
    do_op('{1'b0, 16'd0, 16'd100, 16'd0, 16'd0, 1'b1}, 0, 0);
    // Extra Start strobe during ITER must be ignored.
    do_op(tbl[0], 8, 0);
    // Reset at ITER count 5, then a normal operation.
    do_op(tbl[1], 0, 7);
    do_op(tbl[0], 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
